// File: rtl/uart_tx_periph.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_periph
//  Description : Memory-mapped 8N1 UART transmitter with a small TX FIFO,
//                programmable baud divisor and pollable status register.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_periph #(
  parameter int FIFO_DEPTH   = 4,
  parameter int BAUD_DIV_RST = 867
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic        we,
  input  logic [3:0]  addr,
  input  logic [31:0] wData,
  output logic [31:0] rData,
  output logic        tx
);

  localparam int            PW      = $clog2(FIFO_DEPTH);
  localparam int            CW      = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_BAUDDIV = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t        state_q;
  logic [7:0]    fifo_mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          ovf_q;
  logic [15:0]   baud_div_q;
  logic [15:0]   baud_cnt_q;
  logic [7:0]    shift_q;
  logic [2:0]    idx_q;
  logic          tx_q;

  logic wr_en;
  logic push_req;
  logic push;
  logic pop;
  logic full;
  logic empty;
  logic busy;
  logic tick;
  logic status_wr;
  logic baud_wr;
  logic unused_bits;

  assign wr_en     = sel & we;
  assign push_req  = wr_en & (addr[3:2] == REG_TXDATA);
  assign status_wr = wr_en & (addr[3:2] == REG_STATUS);
  assign baud_wr   = wr_en & (addr[3:2] == REG_BAUDDIV);
  assign full      = (count_q == DEPTH_C);
  assign empty     = (count_q == '0);
  // A push while full is dropped regardless of a same-cycle pop.
  assign push      = push_req & ~full;
  assign pop       = (state_q == S_IDLE) & ~empty;
  assign busy      = (state_q != S_IDLE);
  // >= compare so a smaller divisor written mid-bit cannot strand the counter.
  assign tick      = busy & (baud_cnt_q >= baud_div_q);
  assign tx        = tx_q;

  // Byte-offset low bits and upper write-data bits carry no meaning here.
  assign unused_bits = ^{addr[1:0], wData[31:16]};

  // FIFO occupancy next-state from push/pop.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage; contents are meaningless once the pointers reset.
  always_ff @(posedge clk) begin
    if (reset && push) begin
      fifo_mem_q[wr_ptr_q] <= wData[7:0];
    end
  end

  // FIFO pointers, occupancy, sticky overflow and baud divisor register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      baud_div_q <= 16'(BAUD_DIV_RST);
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      count_q <= count_d;
      if (push_req && full) begin
        ovf_q <= 1'b1;
      end else if (status_wr && wData[3]) begin
        ovf_q <= 1'b0;
      end
      if (baud_wr) begin
        baud_div_q <= wData[15:0];
      end
    end
  end

  // Serialiser FSM with baud counter; tx is registered from the current state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      idx_q      <= '0;
      baud_cnt_q <= '0;
      tx_q       <= 1'b1;
    end else begin
      if (!busy || tick) begin
        baud_cnt_q <= '0;
      end else begin
        baud_cnt_q <= baud_cnt_q + 16'd1;
      end
      case (state_q)
        S_IDLE: begin
          tx_q <= 1'b1;
          if (!empty) begin
            shift_q <= fifo_mem_q[rd_ptr_q];
            idx_q   <= '0;
            state_q <= S_START;
          end
        end
        S_START: begin
          tx_q <= 1'b0;
          if (tick) begin
            state_q <= S_DATA;
          end
        end
        S_DATA: begin
          tx_q <= shift_q[0];
          if (tick) begin
            shift_q <= {1'b0, shift_q[7:1]};
            idx_q   <= idx_q + 3'd1;
            if (idx_q == 3'd7) begin
              state_q <= S_STOP;
            end
          end
        end
        S_STOP: begin
          tx_q <= 1'b1;
          if (tick) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // RAM-like combinational read mux; deselected reads return zero.
  always_comb begin
    rData = '0;
    if (sel) begin
      case (addr[3:2])
        REG_STATUS:  rData = {23'd0, 5'(count_q), ovf_q, busy, empty, full};
        REG_BAUDDIV: rData = {16'd0, baud_div_q};
        default:     rData = '0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_periph.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_periph
//  Description : Self-checking bench for uart_tx_periph. A UART receiver model
//                decodes tx into bytes with start times; bursts are predicted
//                from the FIFO admission rules and compared frame by frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_periph;

  localparam int DEPTH   = 4;
  localparam int DIV_RST = 867;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        sel   = 1'b0;
  logic        we    = 1'b0;
  logic [3:0]  addr  = 4'h0;
  logic [31:0] wData = 32'h0;
  logic [31:0] rData;
  logic        tx;

  int checks  = 0;
  int errors  = 0;
  int cyc     = 0;
  int cur_div = DIV_RST;

  logic [7:0] rx_bytes[$];
  int         rx_start[$];
  bit         rx_ok[$];
  logic [7:0] stim[$];

  uart_tx_periph #(.FIFO_DEPTH(DEPTH), .BAUD_DIV_RST(DIV_RST)) dut (
    .clk  (clk),
    .reset(reset),
    .sel  (sel),
    .we   (we),
    .addr (addr),
    .wData(wData),
    .rData(rData),
    .tx   (tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; addr = a; wData = d;
    step();
    sel = 1'b0; we = 1'b0; addr = 4'h0; wData = 32'h0;
  endtask

  task automatic bus_read(input logic [3:0] a, input logic s, output logic [31:0] d);
    sel = s; we = 1'b0; addr = a;
    #1;
    d = rData;
    sel = 1'b0; addr = 4'h0;
  endtask

  // Receiver model: one frame = 10 bits of (div+1) samples each, must be flat per bit.
  initial begin : rx_monitor
    logic [9:0] bits;
    int sc, per, total;
    bit okf, aborted;
    forever begin
      step();
      if (reset === 1'b1 && tx === 1'b0) begin
        sc = cyc; okf = 1'b1; aborted = 1'b0; per = cur_div + 1; total = 10 * per; bits = '0;
        for (int s = 0; s < total; s++) begin
          if (s > 0) step();
          if (reset !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          if (s % per == 0) bits[s / per] = tx;
          else if (tx !== bits[s / per]) okf = 1'b0;
        end
        if (!aborted) begin
          if (bits[0] !== 1'b0 || bits[9] !== 1'b1) okf = 1'b0;
          rx_bytes.push_back(bits[8:1]);
          rx_start.push_back(sc);
          rx_ok.push_back(okf);
        end
      end
    end
  end

  task automatic wait_frames(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (rx_bytes.size() < target && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (rx_bytes.size() < target) begin
      errors++;
      $display("FAIL %s frames_received got %0d need %0d", tag, rx_bytes.size(), target);
    end
  endtask

  task automatic set_div(input int d, input string tag);
    logic [31:0] r;
    bus_write(4'h8, {16'($urandom()), 16'(d)});
    cur_div = d;
    bus_read(4'h8, 1'b1, r);
    checks++;
    if (r !== {16'h0, 16'(d)}) begin
      errors++;
      $display("FAIL %s bauddiv_readback got %h need %h", tag, r, {16'h0, 16'(d)});
    end
  endtask

  task automatic test_reset();
    logic [31:0] r;
    reset = 1'b0;
    repeat (3) step();
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b need 1", tx); end
    bus_read(4'h4, 1'b1, r);
    checks++;
    if (r !== 32'h0000_0002) begin errors++; $display("FAIL reset_status got %h need 00000002", r); end
    bus_read(4'h8, 1'b1, r);
    checks++;
    if (r !== 32'h0000_0363) begin errors++; $display("FAIL reset_bauddiv got %h need 00000363", r); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_map_misc();
    logic [31:0] r;
    int d;
    bus_read(4'hC, 1'b1, r);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL read_0xC got %h need 0", r); end
    bus_read(4'h0, 1'b1, r);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL read_txdata got %h need 0", r); end
    d = $urandom_range(5, 60);
    set_div(d, "misc");
    bus_read(4'h9, 1'b1, r);
    checks++;
    if (r !== 32'(d)) begin errors++; $display("FAIL addr_lowbits_ignored got %h need %h", r, 32'(d)); end
    bus_write(4'hC, $urandom());
    bus_read(4'h8, 1'b1, r);
    checks++;
    if (r !== 32'(d)) begin errors++; $display("FAIL write_0xC_bauddiv got %h need %h", r, 32'(d)); end
    bus_read(4'h4, 1'b1, r);
    checks++;
    if (r !== 32'h2) begin errors++; $display("FAIL write_0xC_status got %h need 2", r); end
    // Writes with sel low must not land anywhere.
    sel = 1'b0; we = 1'b1; addr = 4'h8; wData = $urandom();
    step();
    addr = 4'h0;
    step();
    we = 1'b0;
    bus_read(4'h8, 1'b1, r);
    checks++;
    if (r !== 32'(d)) begin errors++; $display("FAIL nosel_write_bauddiv got %h need %h", r, 32'(d)); end
    bus_read(4'h4, 1'b1, r);
    checks++;
    if (r !== 32'h2) begin errors++; $display("FAIL nosel_write_status got %h need 2", r); end
    bus_read(4'h8, 1'b0, r);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL nosel_read got %h need 0", r); end
  endtask

  // Drives stim[] as back-to-back TXDATA writes from idle and checks the outcome.
  task automatic run_burst(input int div, input string tag);
    logic [7:0]  exp_q[$];
    logic [31:0] r, exp_st;
    int occ, n, base, w0, frame, cnt;
    bit ovf, bsy;
    n = stim.size(); occ = 0; ovf = 1'b0;
    // First byte leaves the FIFO the cycle after it lands; the rest queue up.
    for (int j = 0; j < n; j++) begin
      if (j == 0) exp_q.push_back(stim[j]);
      else if (occ < DEPTH) begin exp_q.push_back(stim[j]); occ++; end
      else ovf = 1'b1;
    end
    cnt = (n == 1) ? 1 : occ;
    bsy = (n > 1);
    frame = 10 * (div + 1) + 1;
    set_div(div, tag);
    base = rx_bytes.size();
    w0 = 0;
    for (int j = 0; j < n; j++) begin
      bus_write(4'h0, {24'($urandom()), stim[j]});
      if (j == 0) w0 = cyc;
    end
    exp_st = (32'(cnt) << 4) | (ovf ? 32'h8 : 32'h0) | (bsy ? 32'h4 : 32'h0)
           | ((cnt == 0) ? 32'h2 : 32'h0) | ((cnt == DEPTH) ? 32'h1 : 32'h0);
    bus_read(4'h4, 1'b1, r);
    checks++;
    if (r !== exp_st) begin errors++; $display("FAIL %s status_after_burst got %h need %h", tag, r, exp_st); end
    if (ovf) begin
      bus_write(4'h4, 32'($urandom()) | 32'h8);
      exp_st = exp_st & ~32'h8;
      bus_read(4'h4, 1'b1, r);
      checks++;
      if (r !== exp_st) begin errors++; $display("FAIL %s status_ovf_clear got %h need %h", tag, r, exp_st); end
    end
    wait_frames(base + exp_q.size(), exp_q.size() * frame + 40, tag);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < rx_bytes.size()) begin
        checks++;
        if (rx_bytes[base + i] !== exp_q[i] || rx_ok[base + i] !== 1'b1) begin
          errors++;
          $display("FAIL %s frame%0d got byte %h shape_ok %0d need byte %h shape_ok 1",
                   tag, i, rx_bytes[base + i], rx_ok[base + i], exp_q[i]);
        end
        checks++;
        if (i == 0 && rx_start[base] - w0 !== 2) begin
          errors++;
          $display("FAIL %s start_latency got %0d need 2", tag, rx_start[base] - w0);
        end else if (i > 0 && rx_start[base + i] - rx_start[base + i - 1] !== frame) begin
          errors++;
          $display("FAIL %s frame_spacing%0d got %0d need %0d", tag, i,
                   rx_start[base + i] - rx_start[base + i - 1], frame);
        end
      end
    end
    repeat (3) step();
    checks++;
    if (rx_bytes.size() !== base + exp_q.size()) begin
      errors++;
      $display("FAIL %s extra_frames got %0d need %0d", tag, rx_bytes.size() - base, exp_q.size());
    end
    bus_read(4'h4, 1'b1, r);
    checks++;
    if (r !== 32'h2) begin errors++; $display("FAIL %s status_drained got %h need 2", tag, r); end
    stim.delete();
  endtask

  task automatic test_single_frame();
    stim.push_back(8'hA5);
    run_burst(3, "single_a5");
    stim.push_back(8'($urandom()));
    stim.push_back(8'($urandom()));
    run_burst(0, "div0_pair");
  endtask

  task automatic test_overflow();
    for (int j = 0; j < 6; j++) stim.push_back(8'($urandom()));
    run_burst(1, "overflow");
  endtask

  task automatic test_random_bursts();
    int n;
    for (int it = 0; it < 5; it++) begin
      n = $urandom_range(1, 7);
      for (int j = 0; j < n; j++) stim.push_back(8'($urandom()));
      run_burst($urandom_range(0, 3), "random");
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] r;
    int base, bad;
    set_div(3, "rst_mid");
    base = rx_bytes.size();
    for (int j = 0; j < 3; j++) bus_write(4'h0, 32'($urandom()));
    bus_read(4'h4, 1'b1, r);
    checks++;
    if (r !== 32'h24) begin errors++; $display("FAIL rst_mid status_before got %h need 00000024", r); end
    repeat (6) step();
    reset = 1'b0;
    step();
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL rst_mid tx_after_reset got %b need 1", tx); end
    bus_read(4'h4, 1'b1, r);
    checks++;
    if (r !== 32'h2) begin errors++; $display("FAIL rst_mid status_in_reset got %h need 2", r); end
    bus_read(4'h8, 1'b1, r);
    checks++;
    if (r !== 32'h363) begin errors++; $display("FAIL rst_mid bauddiv_in_reset got %h need 363", r); end
    reset = 1'b1;
    cur_div = DIV_RST;
    bad = 0;
    for (int k = 0; k < 200; k++) begin
      step();
      if (tx !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0 || rx_bytes.size() != base) begin
      errors++;
      $display("FAIL rst_mid no_more_frames got low_samples %0d frames %0d need 0 0", bad, rx_bytes.size() - base);
    end
    bus_read(4'h4, 1'b1, r);
    checks++;
    if (r !== 32'h2) begin errors++; $display("FAIL rst_mid status_after got %h need 2", r); end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    test_reset();
    test_map_misc();
    test_single_frame();
    test_overflow();
    test_random_bursts();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
